// File: rtl/overlay_pkg.sv
// Shared types for the overlay fetch controller: arbiter states and the RGBA pixel layout.
package overlay_pkg;

    localparam int OVL_ADDR_W   = 25;
    localparam int RGBA_FIELD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        FLUSH
    } ovl_state_e;

    // Pixel word layout, MSB first: a[15:12] b[11:8] g[7:4] r[3:0].
    typedef struct packed {
        logic [RGBA_FIELD_W-1:0] a;
        logic [RGBA_FIELD_W-1:0] b;
        logic [RGBA_FIELD_W-1:0] g;
        logic [RGBA_FIELD_W-1:0] r;
    } rgba_t;

endpackage

// File: rtl/ovl_fifo.sv
// Small synchronous FIFO with show-ahead head word; flush empties it in one cycle.
module ovl_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/overlay_fetch_ctrl.sv
// Arbitrates the overlay SDRAM port: HPS download writes first, pixel prefetch reads otherwise,
// and streams one RGBA word per active pixel from the prefetch FIFO.
module overlay_fetch_ctrl
    import overlay_pkg::*;
#(
    parameter int                ADDR_W     = OVL_ADDR_W,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic              en,
    input  logic              vs,
    input  logic              de,
    input  logic              ce_pix,
    output logic [15:0]       pix_data,
    output logic              underrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ovl_state_e        state_q, state_d;
    logic              vs_q;
    logic              flush_req_q, flush_req_d;
    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_rd_q, mem_rd_d;
    rgba_t             pix_q, pix_d;
    logic              underrun_q, underrun_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    rgba_t             fifo_dout;
    logic              vs_rise, can_read;

    assign vs_rise  = vs & ~vs_q;
    assign can_read = en & ~dl_active & (fifo_count < CNT_W'(FIFO_DEPTH)) & ~flush_req_q;

    ovl_fifo #(
        .WIDTH ($bits(rgba_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .din     (mem_dout),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        mem_rd_d    = 1'b0;
        pix_d       = pix_q;
        underrun_d  = underrun_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        flush_req_d = (flush_req_q & (state_q != FLUSH)) | vs_rise;

        // A strobe while the holding register is occupied is dropped.
        if (dl_wr && dl_active && !wr_pend_q) begin
            wr_pend_d = 1'b1;
            wr_addr_d = dl_addr;
            wr_data_d = dl_data;
        end

        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d    = WRITE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = wr_addr_q;
                    mem_din_d  = wr_data_q;
                end else if (can_read) begin
                    state_d    = READ;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = rd_addr_q;
                end else if (flush_req_q) begin
                    state_d = FLUSH;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    wr_pend_d = 1'b0;
                end
            end
            READ: begin
                if (mem_ready) begin
                    fifo_push = ~flush_req_q;
                    rd_addr_d = rd_addr_q + ADDR_W'(2);
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                fifo_flush = 1'b1;
                rd_addr_d  = BASE_ADDR;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush outranks a same-cycle pixel pop.
        if (state_q == FLUSH) begin
            pix_d      = '0;
            underrun_d = 1'b0;
        end else if (!en || dl_active) begin
            pix_d = '0;
        end else if (ce_pix && de) begin
            if (!fifo_empty) begin
                pix_d    = fifo_dout;
                fifo_pop = 1'b1;
            end else begin
                pix_d      = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vs_q        <= 1'b0;
            flush_req_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= BASE_ADDR;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            pix_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs;
            flush_req_q <= flush_req_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_rd_q    <= mem_rd_d;
            pix_q       <= pix_d;
            underrun_q  <= underrun_d;
        end
    end

    assign dl_wait  = wr_pend_q;
    assign pix_data = pix_q;
    assign underrun = underrun_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_overlay_fetch_ctrl.sv
// Directed + randomized bench for overlay_fetch_ctrl; SDRAM model returns data = byte address.
module tb_overlay_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        en, vs, de, ce_pix;
    logic [15:0] pix_data;
    logic        underrun;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_rd, mem_ready;
    logic [15:0] mem_dout;

    overlay_fetch_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_wait   (dl_wait),
        .en        (en),
        .vs        (vs),
        .de        (de),
        .ce_pix    (ce_pix),
        .pix_data  (pix_data),
        .underrun  (underrun),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .mem_dout  (mem_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    // SDRAM model: one outstanding request, answered 'lat' cycles after it is seen.
    int          lat = 2;
    bit          busy = 0;
    bit          pend_rd = 0;
    logic [24:0] pend_addr = '0;
    int          cnt = 0;
    int          rd_ready_cyc = 0;
    int          we_cyc = 0;
    bit          we_done = 0;
    logic [24:0] rd_log[$];
    logic [32:0] we_log[$];

    initial begin
        mem_ready = 1'b0;
        mem_dout  = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!reset_n) begin
                busy = 0;
            end else begin
                if (busy) begin
                    if (cnt == 0) begin
                        mem_ready = 1'b1;
                        mem_dout  = pend_rd ? pend_addr[15:0] : 16'hDEAD;
                        busy      = 0;
                        if (pend_rd) rd_ready_cyc = cyc;
                        else         we_done = 1;
                    end else begin
                        cnt--;
                    end
                end
                if (mem_rd || mem_we) begin
                    busy      = 1;
                    cnt       = lat - 1;
                    pend_addr = mem_addr;
                    pend_rd   = mem_rd;
                    if (mem_rd) begin
                        rd_log.push_back(mem_addr);
                    end else begin
                        we_log.push_back({mem_addr, mem_din});
                        we_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One ce_pix cycle with de high; returns pix_data one clock later.
    task automatic pixel(output logic [15:0] v);
        @(negedge clk);
        de     = 1'b1;
        ce_pix = 1'b1;
        @(posedge clk);
        #1 v = pix_data;
        @(negedge clk);
        de     = 1'b0;
        ce_pix = 1'b0;
    endtask

    task automatic wait_rd(input int n, input string tag);
        int t = 0;
        while (rd_log.size() < n && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check(tag, 64'(rd_log.size() >= n), 64'd1);
    endtask

    // Waits until the model sees a read of address 0 newer than any seen so far.
    task automatic wait_frame(input string tag);
        int n = rd_log.size();
        int t = 0;
        bit found = 0;
        while (!found && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
            if (rd_log.size() > n && rd_log[rd_log.size()-1] == 25'd0) found = 1;
        end
        check(tag, 64'(found), 64'd1);
    endtask

    task automatic dl_write(input logic [24:0] a, input logic [7:0] d, input string tag);
        int t = 0;
        @(negedge clk);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        @(negedge clk);
        dl_wr = 1'b0;
        while (dl_wait && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(tag, 64'(dl_wait), 64'd0);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] exp_pix;
        logic [32:0] exp_w[$];
        int          stall_bad;
        int          t;

        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        en = 1'b0; vs = 1'b0; de = 1'b0; ce_pix = 1'b0;

        // Reset values
        #7;
        check("rst_pix", 64'(pix_data), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_dl_wait", 64'(dl_wait), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_din", 64'(mem_din), 64'd0);
        idle(3);
        reset_n = 1'b1;

        // Prefetch fills exactly FIFO_DEPTH words at 0,2,..,14, then stops
        lat = 2;
        en  = 1'b1;
        idle(120);
        check("fill_count", 64'(rd_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("fill_addr", 64'(rd_log[i]), 64'(2 * i));
        idle(50);
        check("fill_stops", 64'(rd_log.size()), 64'd8);

        // 20 active pixels stream words 0x0000..0x0026 without underrun
        exp_pix = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            pixel(v);
            check("stream_pix", 64'(v), 64'(exp_pix));
            exp_pix += 16'd2;
            idle(7);
        end
        check("stream_underrun", 64'(underrun), 64'd0);
        idle(40);
        check("stream_reads", 64'(rd_log.size()), 64'd28);

        // Download write captured while a read is in flight
        lat = 10;
        pixel(v);
        check("pre_dl_pix", 64'(v), 64'(exp_pix));
        exp_pix += 16'd2;
        wait_rd(29, "dl_read_issued");
        we_done = 0;
        @(negedge clk);
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 25'h10;
        dl_data   = 8'hA5;
        @(posedge clk);
        #1 check("dl_wait_rise", 64'(dl_wait), 64'd1);
        @(negedge clk);
        dl_wr = 1'b0;
        stall_bad = 0;
        t = 0;
        while (!we_done && t < 200) begin
            @(posedge clk);
            #1;
            t++;
            if (!we_done && dl_wait !== 1'b1) stall_bad++;
        end
        check("dl_write_done", 64'(we_done), 64'd1);
        check("dl_wait_held", 64'(stall_bad), 64'd0);
        check("dl_wait_drop", 64'(dl_wait), 64'd0);
        check("dl_we_count", 64'(we_log.size()), 64'd1);
        check("dl_we_addr_data", 64'(we_log[0]), 64'({25'h10, 8'hA5}));
        check("dl_we_after_read", 64'(we_cyc - rd_ready_cyc), 64'd2);
        pixel(v);
        check("dl_active_pix", 64'(v), 64'd0);
        check("dl_active_underrun", 64'(underrun), 64'd0);
        dl_active = 1'b0;
        idle(20);

        // Frame start while the read of 0x40 is pending
        for (int i = 0; i < 4; i++) begin
            pixel(v);
            check("pre_vs_pix", 64'(v), 64'(exp_pix));
            exp_pix += 16'd2;
            if (i < 3) idle(15);
        end
        wait_rd(33, "vs_read_issued");
        check("vs_pending_busy", 64'(busy), 64'd1);
        check("vs_pending_addr", 64'(pend_addr), 64'h40);
        @(negedge clk);
        vs = 1'b1;
        wait_rd(34, "vs_next_read");
        check("vs_restart_addr", 64'(rd_log[33]), 64'd0);
        vs = 1'b0;
        idle(150);
        pixel(v);
        check("vs_first_pix", 64'(v), 64'd0);
        check("vs_underrun", 64'(underrun), 64'd0);
        exp_pix = 16'd2;
        idle(30);

        // Starvation: slow memory, ce_pix every 2 clocks
        lat = 40;
        for (int i = 0; i < 12; i++) begin
            pixel(v);
            check("starve_pix", 64'(v), (i < 8) ? 64'(exp_pix) : 64'd0);
            if (i < 8) exp_pix += 16'd2;
        end
        check("starve_underrun", 64'(underrun), 64'd1);
        idle(100);
        check("starve_sticky", 64'(underrun), 64'd1);
        @(negedge clk);
        vs = 1'b1;
        wait_frame("starve_frame");
        check("starve_cleared", 64'(underrun), 64'd0);
        vs = 1'b0;

        // Randomized downloads then a randomized pixel stream
        we_log.delete();
        dl_active = 1'b1;
        idle(50);
        for (int i = 0; i < 6; i++) begin
            logic [24:0] a;
            logic [7:0]  d;
            a   = 25'($urandom());
            d   = 8'($urandom());
            lat = int'($urandom_range(1, 5));
            exp_w.push_back({a, d});
            dl_write(a, d, "rnd_dl_wait");
            idle(int'($urandom_range(0, 4)));
        end
        check("rnd_we_count", 64'(we_log.size()), 64'(exp_w.size()));
        for (int i = 0; i < 6; i++) check("rnd_we", 64'(we_log[i]), 64'(exp_w[i]));
        dl_active = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        wait_frame("rnd_frame");
        vs = 1'b0;
        idle(120);
        exp_pix = 16'd0;
        for (int i = 0; i < 16; i++) begin
            lat = int'($urandom_range(1, 5));
            pixel(v);
            check("rnd_pix", 64'(v), 64'(exp_pix));
            exp_pix += 16'd2;
            idle(int'($urandom_range(8, 15)));
        end
        check("rnd_underrun", 64'(underrun), 64'd0);

        // Reset asserted during a WRITE
        lat = 20;
        dl_active = 1'b1;
        idle(30);
        we_log.delete();
        @(negedge clk);
        dl_wr   = 1'b1;
        dl_addr = 25'h1234;
        dl_data = 8'h5A;
        @(negedge clk);
        dl_wr = 1'b0;
        t = 0;
        while (we_log.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_we_addr_data", 64'(we_log.size() > 0 ? we_log[0] : 33'd0), 64'({25'h1234, 8'h5A}));
        idle(3);
        check("mid_dl_wait", 64'(dl_wait), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_dl_wait", 64'(dl_wait), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_mem_din", 64'(mem_din), 64'd0);
        check("arst_mem_we", 64'(mem_we), 64'd0);
        check("arst_mem_rd", 64'(mem_rd), 64'd0);
        check("arst_pix", 64'(pix_data), 64'd0);
        check("arst_underrun", 64'(underrun), 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        dl_active = 1'b0;
        pixel(v);
        check("arst_fifo_empty_pix", 64'(v), 64'd0);
        check("arst_fifo_empty_underrun", 64'(underrun), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
